// File: rtl/fp_mul_iter.sv
// Iterative IEEE-style floating-point multiplier (RNE, flush-to-zero, canonical qNaN).
// Latency: fixed N+1 edges from accept to o_valid, N = (FRAC_W+1)/BPC, for every operand class.
// Backpressure: o_ready high only in IDLE/DONE; i_valid while busy is ignored, result held until next accept.
//
// Ports:
//   i_clk, i_rst_n      clock (rising edge), asynchronous active-low reset
//   i_valid / o_ready   operand handshake; accept on i_valid && o_ready
//   i_a, i_b            operands {sign, exp[EXP_W], frac[FRAC_W]}
//   o_valid             result valid, held until the next accept
//   o_result, o_flags   product and {invalid, overflow, underflow, inexact}
module fp_mul_iter #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23,
  parameter int BPC    = 1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [EXP_W+FRAC_W:0]   i_a,
  input  logic [EXP_W+FRAC_W:0]   i_b,
  output logic                    o_valid,
  output logic [EXP_W+FRAC_W:0]   o_result,
  output logic [3:0]              o_flags
);

  localparam int W     = 1 + EXP_W + FRAC_W;
  localparam int M     = FRAC_W + 1;
  localparam int N     = M / BPC;
  localparam int EW    = EXP_W + 2;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [EW-1:0]    BIAS_E = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic [EW-1:0]    E_MAX  = EW'((1 << EXP_W) - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [W-1:0]     QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(FRAC_W-1){1'b0}}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_NORM = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [M-1:0]     ma_q, ma_d, mb_q, mb_d;
  logic [2*M-1:0]   acc_q, acc_d;
  logic             valid_q, valid_d;
  logic [W-1:0]     result_q, result_d;
  logic [3:0]       flags_q, flags_d;

  logic accept;
  assign o_ready  = (state_q == S_IDLE) || (state_q == S_DONE);
  assign accept   = i_valid && o_ready;
  assign o_valid  = valid_q;
  assign o_result = result_q;
  assign o_flags  = flags_q;

  // Operand fields of the registered operands.
  logic              sa, sb, s_res;
  logic [EXP_W-1:0]  ea, eb;
  logic [FRAC_W-1:0] fa, fb;
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;

  always_comb begin
    sa     = a_q[W-1];
    sb     = b_q[W-1];
    ea     = a_q[W-2:FRAC_W];
    eb     = b_q[W-2:FRAC_W];
    fa     = a_q[FRAC_W-1:0];
    fb     = b_q[FRAC_W-1:0];
    s_res  = sa ^ sb;
    a_nan  = (&ea) && (|fa);
    b_nan  = (&eb) && (|fb);
    a_inf  = (&ea) && !(|fa);
    b_inf  = (&eb) && !(|fb);
    // exp == 0 covers zero and subnormals, both treated as zero
    a_zero = (ea == '0);
    b_zero = (eb == '0);
  end

  // Significands of the incoming operands; subnormals load as zero.
  logic [M-1:0] in_ma, in_mb;
  always_comb begin
    in_ma = (|i_a[W-2:FRAC_W]) ? {1'b1, i_a[FRAC_W-1:0]} : '0;
    in_mb = (|i_b[W-2:FRAC_W]) ? {1'b1, i_b[FRAC_W-1:0]} : '0;
  end

  // Shift-add step: BPC partial products from the low multiplier bits are
  // added into the upper half, then the whole accumulator shifts right BPC.
  // After N steps the accumulator holds the exact 2M-bit product.
  logic [M+BPC-1:0] pp, hi_sum;
  always_comb begin
    pp = '0;
    for (int j = 0; j < BPC; j++) begin
      if (mb_q[j]) pp = pp + ({{BPC{1'b0}}, ma_q} << j);
    end
    hi_sum = {{BPC{1'b0}}, acc_q[2*M-1:M]} + pp;
  end

  // Normalise and round the product.
  logic              norm, guard, sticky, round_up, carry, inexact, ovf, unf;
  logic [2*M-2:0]    sh;
  logic [FRAC_W-1:0] frac_t;
  logic [FRAC_W:0]   rnd;
  logic [EW-1:0]     e_calc;
  logic [W-1:0]      norm_res;
  logic [3:0]        norm_flags;

  always_comb begin
    norm     = acc_q[2*M-1];
    // sh has the leading one dropped: bits below it are fraction, guard, sticky
    sh       = norm ? acc_q[2*M-2:0] : {acc_q[2*M-3:0], 1'b0};
    frac_t   = sh[2*M-2:M];
    guard    = sh[M-1];
    sticky   = |sh[M-2:0];
    round_up = guard & (sticky | frac_t[0]);
    rnd      = {1'b0, frac_t} + {{FRAC_W{1'b0}}, round_up};
    // carry out means the fraction wrapped to zero: mantissa is 1.0 * 2^(e+1)
    carry    = rnd[FRAC_W];
    inexact  = guard | sticky;
    e_calc   = {2'b00, ea} + {2'b00, eb} - BIAS_E
             + {{(EW-1){1'b0}}, norm} + {{(EW-1){1'b0}}, carry};
    ovf      = !e_calc[EW-1] && (e_calc >= E_MAX);
    unf      = e_calc[EW-1] || (e_calc == '0);

    norm_res   = {s_res, e_calc[EXP_W-1:0], rnd[FRAC_W-1:0]};
    norm_flags = {3'b000, inexact};
    if (ovf) begin
      norm_res   = {s_res, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      norm_flags = 4'b0101;
    end else if (unf) begin
      norm_res   = {s_res, {(W-1){1'b0}}};
      norm_flags = 4'b0011;
    end

    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
      norm_res   = QNAN;
      norm_flags = 4'b1000;
    end else if (a_inf || b_inf) begin
      norm_res   = {s_res, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      norm_flags = 4'b0000;
    end else if (a_zero || b_zero) begin
      norm_res   = {s_res, {(W-1){1'b0}}};
      norm_flags = 4'b0000;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    ma_d     = ma_q;
    mb_d     = mb_q;
    acc_d    = acc_q;
    valid_d  = valid_q;
    result_d = result_q;
    flags_d  = flags_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          a_d     = i_a;
          b_d     = i_b;
          ma_d    = in_ma;
          mb_d    = in_mb;
          acc_d   = '0;
          cnt_d   = '0;
          valid_d = 1'b0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        acc_d = {hi_sum, acc_q[M-1:BPC]};
        mb_d  = mb_q >> BPC;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) state_d = S_NORM;
      end
      S_NORM: begin
        result_d = norm_res;
        flags_d  = norm_flags;
        valid_d  = 1'b1;
        state_d  = S_DONE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      ma_q     <= '0;
      mb_q     <= '0;
      acc_q    <= '0;
      valid_q  <= 1'b0;
      result_q <= '0;
      flags_q  <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      ma_q     <= ma_d;
      mb_q     <= mb_d;
      acc_q    <= acc_d;
      valid_q  <= valid_d;
      result_q <= result_d;
      flags_q  <= flags_d;
    end
  end

endmodule

// File: tb/tb_fp_mul_iter.sv
// Bench for fp_mul_iter: two instances (BPC=1 and BPC=2) share stimulus.
// Expected results come from an arithmetic reference model or fixed constants.
// A monitor pops per-instance queues whenever o_valid rises.
module tb_fp_mul_iter;

  logic        i_clk   = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_valid = 1'b0;
  logic [31:0] i_a     = '0;
  logic [31:0] i_b     = '0;
  logic        rdy [2];
  logic        vld [2];
  logic [31:0] res [2];
  logic [3:0]  fl  [2];

  always #5 i_clk = ~i_clk;

  fp_mul_iter #(.EXP_W(8), .FRAC_W(23), .BPC(1)) u_dut1 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(rdy[0]),
    .i_a(i_a), .i_b(i_b), .o_valid(vld[0]), .o_result(res[0]), .o_flags(fl[0]));

  fp_mul_iter #(.EXP_W(8), .FRAC_W(23), .BPC(2)) u_dut2 (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(rdy[1]),
    .i_a(i_a), .i_b(i_b), .o_valid(vld[1]), .o_result(res[1]), .o_flags(fl[1]));

  typedef struct {
    logic [31:0] r;
    logic [3:0]  f;
    int          acc;
  } exp_t;

  exp_t q [2][$];
  exp_t ex;
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  int   lat [2] = '{25, 13};
  bit   busy [2] = '{0, 0};
  bit   pv [2] = '{0, 0};
  int   rdy_hi [2] = '{0, 0};

  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp_v);
    end
  endtask

  // Reference: exact integer product, round-to-nearest-even by remainder compare.
  function automatic logic [35:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    bit s, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, inx;
    int ea, eb, e, shamt;
    longint unsigned ma, mb, prod, qt, r, half;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    a_nan  = (ea == 255) && (a[22:0] != 0);
    b_nan  = (eb == 255) && (b[22:0] != 0);
    a_inf  = (ea == 255) && (a[22:0] == 0);
    b_inf  = (eb == 255) && (b[22:0] == 0);
    a_zero = (ea == 0);
    b_zero = (eb == 0);
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero))
      return {4'b1000, 32'h7FC00000};
    if (a_inf || b_inf) return {4'b0000, s, 8'hFF, 23'd0};
    if (a_zero || b_zero) return {4'b0000, s, 31'd0};
    ma    = 64'h800000 + 64'(a[22:0]);
    mb    = 64'h800000 + 64'(b[22:0]);
    prod  = ma * mb;
    e     = ea + eb - 127;
    shamt = 23;
    if (prod >= (64'd1 << 47)) begin
      shamt = 24;
      e++;
    end
    qt   = prod >> shamt;
    r    = prod - (qt << shamt);
    half = 64'd1 << (shamt - 1);
    inx  = (r != 0);
    if (r > half || (r == half && qt[0])) qt++;
    if (qt == (64'd1 << 24)) begin
      qt = qt >> 1;
      e++;
    end
    if (e >= 255) return {4'b0101, s, 8'hFF, 23'd0};
    if (e <= 0) return {4'b0011, s, 31'd0};
    return {3'b000, inx, s, e[7:0], qt[22:0]};
  endfunction

  function automatic logic [31:0] rand_op();
    logic [7:0]  e;
    logic [22:0] f;
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0: e = 8'd0;
      1: e = 8'hFF;
      2: e = 8'($urandom_range(200, 254));
      3: e = 8'($urandom_range(1, 60));
      default: e = 8'($urandom_range(100, 154));
    endcase
    f = 23'($urandom);
    if ($urandom_range(0, 4) == 0) f = '0;
    return {1'($urandom), e, f};
  endfunction

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic [3:0] ef, input bit push);
    int t;
    t = 0;
    @(negedge i_clk);
    while (!rdy[0] && t < 100) begin
      @(negedge i_clk);
      t++;
    end
    if (t >= 100) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout: o_ready stayed 0 for %0d cycles, expected 1", t);
      return;
    end
    i_valid = 1'b1;
    i_a     = a;
    i_b     = b;
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("valid_drop_on_accept dut%0d", i), 32'(vld[i]), 32'd0);
      busy[i]   = 1'b1;
      rdy_hi[i] = 0;
      if (push) q[i].push_back('{er, ef, cyc});
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s o_ready dut%0d", tag, i), 32'(rdy[i]), 32'd1);
      chk($sformatf("%s o_valid dut%0d", tag, i), 32'(vld[i]), 32'd0);
      chk($sformatf("%s o_result dut%0d", tag, i), res[i], 32'd0);
      chk($sformatf("%s o_flags dut%0d", tag, i), 32'(fl[i]), 32'd0);
    end
  endtask

  // Monitor: compare whenever o_valid rises on either instance.
  always @(posedge i_clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (i_rst_n && vld[i] && !pv[i]) begin
        if (q[i].size() == 0) begin
          tests++;
          fails++;
          $display("FAIL spurious_valid dut%0d: got o_valid=1, expected 0 (nothing pending)", i);
        end else begin
          ex = q[i].pop_front();
          chk($sformatf("result dut%0d", i), res[i], ex.r);
          chk($sformatf("flags dut%0d", i), 32'(fl[i]), 32'(ex.f));
          chk($sformatf("latency dut%0d", i), 32'(cyc - ex.acc), 32'(lat[i]));
          chk($sformatf("ready_low_while_busy dut%0d", i), 32'(rdy_hi[i]), 32'd0);
        end
        busy[i] = 1'b0;
      end else if (i_rst_n && busy[i] && rdy[i]) begin
        rdy_hi[i]++;
      end
      pv[i] = vld[i];
    end
  end

  logic [31:0] da [6] = '{32'h3FC00000, 32'h3F800001, 32'h7F800000, 32'hFF800000, 32'h7F000000, 32'h00800000};
  logic [31:0] db [6] = '{32'h40000000, 32'h3F800001, 32'h00000000, 32'h40000000, 32'h7F000000, 32'h80800000};
  logic [31:0] dr [6] = '{32'h40400000, 32'h3F800002, 32'h7FC00000, 32'hFF800000, 32'h7F800000, 32'h80000000};
  logic [3:0]  df [6] = '{4'b0000, 4'b0001, 4'b1000, 4'b0000, 4'b0101, 4'b0011};

  initial begin
    logic [31:0] a, b;
    logic [35:0] m;
    int t;

    #12;
    chk_reset_outputs("reset");
    @(negedge i_clk);
    i_rst_n = 1'b1;

    for (int k = 0; k < 6; k++) issue(da[k], db[k], dr[k], df[k], 1'b1);

    // Abort an operation in its 10th CALC cycle.
    issue(32'h3FC00000, 32'h40000000, 32'h0, 4'h0, 1'b0);
    repeat (9) @(posedge i_clk);
    @(negedge i_clk);
    i_rst_n = 1'b0;
    busy[0] = 1'b0;
    busy[1] = 1'b0;
    #1;
    chk_reset_outputs("mid_calc_reset");
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    issue(32'h40000000, 32'h40000000, 32'h40800000, 4'b0000, 1'b1);

    for (int k = 0; k < 120; k++) begin
      a = rand_op();
      b = rand_op();
      m = ref_mul(a, b);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge i_clk);
      issue(a, b, m[31:0], m[35:32], 1'b1);
    end

    t = 0;
    while ((q[0].size() != 0 || q[1].size() != 0) && t < 200) begin
      @(posedge i_clk);
      t++;
    end
    repeat (3) @(posedge i_clk);
    #2;
    chk("drain dut0 pending", 32'(q[0].size()), 32'd0);
    chk("drain dut1 pending", 32'(q[1].size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
